eigen_sequencer: RTL

Batch controller that drives the power-iteration engine from the initiator side of its `start`/`f` handshake. It launches the engine `NUM_VEC` times back to back and seeds each run. It captures each converged vector and its iteration count into an internal result buffer, which downstream fetal-ECG separation logic reads through a random-access port. It sits between the top-level ECG controller and the engine, and owns the engine's reset and start lines.

---
 rtl/eigen_sequencer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/eigen_sequencer.sv
// rtl/eigen_sequencer.sv - batch launcher and result collector for the power-iteration engine
// Optional run watchdog: define EIGEN_SEQ_TIMEOUT_EN.
module eigen_sequencer #(
  parameter int SIZE_N         = 8,
  parameter int NUM_VEC        = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int AW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1,
  localparam int IW = $clog2(NUM_VEC) + 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [1:0][SIZE_N-1:0][63:0]   init_vectors,
  output logic                           eng_rst,
  output logic                           eng_start,
  output logic [1:0][SIZE_N-1:0][63:0]   eng_vectors,
  input  logic [SIZE_N-1:0][63:0]        eng_vector,
  input  logic [31:0]                    eng_k,
  input  logic                           eng_f,
  input  logic [AW-1:0]                  rd_addr,
  output logic [SIZE_N-1:0][63:0]        rd_vector,
  output logic [31:0]                    rd_k,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LAUNCH, S_WAIT, S_CAPTURE, S_DONE
  } state_t;

  typedef logic [SIZE_N-1:0][63:0] vec_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_VEC - 1);
  localparam logic [AW:0]   NV       = (AW + 1)'(NUM_VEC);

  state_t                     state_q, state_d;
  logic [IW-1:0]              idx_q, idx_d;
  vec_t                       vbuf_q [NUM_VEC];
  vec_t                       vbuf_d [NUM_VEC];
  logic [31:0]                kbuf_q [NUM_VEC];
  logic [31:0]                kbuf_d [NUM_VEC];
  logic [1:0][SIZE_N-1:0][63:0] seed_q, seed_d;
  logic                       eng_rst_q, eng_rst_d;
  logic                       eng_start_q, eng_start_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;
  logic                       timeout;

`ifdef EIGEN_SEQ_TIMEOUT_EN
  logic [31:0] wdog_q, wdog_d;

  always_comb begin
    wdog_d = wdog_q;
    if (state_q == S_LAUNCH) begin
      wdog_d = '0;
    end else if (state_q == S_WAIT) begin
      wdog_d = wdog_q + 32'd1;
    end
  end

  // Fires on the WAIT cycle in which the count would reach the limit.
  assign timeout = (state_q == S_WAIT) && !eng_f &&
                   ((wdog_q + 32'd1) >= 32'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vbuf_d  = vbuf_q;
    kbuf_d  = kbuf_q;
    seed_d  = seed_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_CLEAR;
          idx_d   = '0;
          err_d   = 1'b0;
          seed_d  = init_vectors;
          for (int i = 0; i < NUM_VEC; i++) begin
            vbuf_d[i] = '0;
            kbuf_d[i] = '0;
          end
        end
      end
      S_CLEAR:  state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (eng_f || timeout) begin
          state_d = S_CAPTURE;
          vbuf_d[idx_q[AW-1:0]] = timeout ? '0 : eng_vector;
          kbuf_d[idx_q[AW-1:0]] = timeout ? 32'hFFFF_FFFF : eng_k;
          if (timeout) begin
            err_d = 1'b1;
          end
        end
      end
      S_CAPTURE: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          // Next run is seeded with the vector just captured.
          state_d   = S_CLEAR;
          idx_d     = idx_q + 1'b1;
          seed_d[0] = init_vectors[0];
          seed_d[1] = vbuf_q[idx_q[AW-1:0]];
        end
      end
      default: state_d = S_IDLE;
    endcase

    eng_rst_d   = (state_d == S_IDLE) || (state_d == S_CLEAR) || (state_d == S_DONE);
    eng_start_d = (state_d == S_LAUNCH) || (state_d == S_WAIT);
    busy_d      = (state_d == S_CLEAR) || (state_d == S_LAUNCH) ||
                  (state_d == S_WAIT)  || (state_d == S_CAPTURE);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      seed_q      <= '0;
      eng_rst_q   <= 1'b1;
      eng_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < NUM_VEC; i++) begin
        vbuf_q[i] <= '0;
        kbuf_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      seed_q      <= seed_d;
      eng_rst_q   <= eng_rst_d;
      eng_start_q <= eng_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      vbuf_q      <= vbuf_d;
      kbuf_q      <= kbuf_d;
    end
  end

  always_comb begin
    rd_vector = '0;
    rd_k      = '0;
    if ({1'b0, rd_addr} < NV) begin
      rd_vector = vbuf_q[rd_addr];
      rd_k      = kbuf_q[rd_addr];
    end
  end

  assign eng_rst     = eng_rst_q;
  assign eng_start   = eng_start_q;
  assign eng_vectors = seed_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule
